// File: rtl/mem_parity_ram.sv
// mem_parity_ram: parity-protected RAM, cleared by an init FSM after reset.
// Define MEM_PARITY_INJECT_EN to add the inj_err port that flips stored parity on writes.
module mem_parity_ram #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              err_clr,
`ifdef MEM_PARITY_INJECT_EN
  input  logic              inj_err,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_parity,
  output logic              rd_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              init_busy
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic POL = PARITY_ODD != 0;

  logic [0:0] state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] rd_word;
  logic inj, run, wr_ok, rd_ok, wr_par, mismatch;

`ifdef MEM_PARITY_INJECT_EN
  assign inj = inj_err;
`else
  assign inj = 1'b0;
`endif

  assign run       = state == RUN;
  assign init_busy = !run;
  assign wr_ok     = run && wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok     = run && rd_en && ({1'b0, rd_addr} < DEPTH_L);
  assign wr_par    = (^wr_data) ^ POL ^ inj;
  assign rd_word   = mem[rd_addr[IW-1:0]];
  assign mismatch  = rd_ok && (((^rd_word[DATA_W-1:0]) ^ POL) != rd_word[DATA_W]);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else if (!run) begin
      ptr <= ptr + 1'b1;
      if (ptr == LAST) state <= RUN;
    end

  // Array has no reset; the INIT sweep establishes valid contents.
  always_ff @(posedge clk)
    if (!run) mem[ptr[IW-1:0]] <= {POL, {DATA_W{1'b0}}};
    else if (wr_ok) mem[wr_addr[IW-1:0]] <= {wr_par, wr_data};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data    <= '0;
      rd_parity  <= 1'b0;
      rd_valid   <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) {rd_parity, rd_data} <= rd_word;
      parity_err <= !err_clr && (parity_err || mismatch);
      err_count  <= err_clr ? '0 : (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;
    end
endmodule

// File: tb/tb_mem_parity_ram.sv
// tb_mem_parity_ram: random and directed stimulus against an array-based reference model.
module tb_mem_parity_ram;
  localparam int DW = 8, DEPTH = 8, AW = 4, PODD = 0, CW = 2, CMAX = 3;

  logic clk = 0, rst_n = 0, wr_en = 0, rd_en = 0, err_clr = 0, inj_err = 0;
  logic [AW-1:0] wr_addr = 0, rd_addr = 0;
  logic [DW-1:0] wr_data = 0, rd_data;
  logic rd_parity, rd_valid, parity_err, init_busy;
  logic [CW-1:0] err_count;

  mem_parity_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .PARITY_ODD(PODD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .err_clr(err_clr),
`ifdef MEM_PARITY_INJECT_EN
    .inj_err(inj_err),
`endif
    .rd_data(rd_data), .rd_parity(rd_parity), .rd_valid(rd_valid),
    .parity_err(parity_err), .err_count(err_count), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int md [DEPTH];
  int mp [DEPTH];
  int init_left, e_data, e_par, e_valid, e_err, e_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int par(input int d);
    return ($countones(d[DW-1:0]) + PODD) % 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin md[i] = 0; mp[i] = par(0); end
    {e_data, e_par, e_valid, e_err, e_cnt} = '0;
    init_left = DEPTH;
  endtask

  task automatic check_all();
    chk("rd_valid", int'(rd_valid), e_valid);
    chk("rd_data", int'(rd_data), e_data);
    chk("rd_parity", int'(rd_parity), e_par);
    chk("parity_err", int'(parity_err), e_err);
    chk("err_count", int'(err_count), e_cnt);
    chk("init_busy", int'(init_busy), int'(init_left > 0));
  endtask

  task automatic tick(input logic we, input int wa, input int wd, input logic re, input int ra,
                      input logic clr, input logic ij);
    logic mis;
    wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
    rd_en = re; rd_addr = AW'(ra); err_clr = clr; inj_err = ij;
    @(posedge clk);
    mis = 0;
    if (init_left > 0) begin
      init_left--;
      e_valid = 0;
    end else begin
      e_valid = int'(re && ra < DEPTH);
      if (e_valid != 0) begin
        e_data = md[ra];
        e_par = mp[ra];
        mis = e_par != par(e_data);
      end
`ifdef MEM_PARITY_INJECT_EN
      if (we && wa < DEPTH) begin md[wa] = wd; mp[wa] = par(wd) ^ int'(ij); end
`else
      if (we && wa < DEPTH) begin md[wa] = wd; mp[wa] = par(wd); end
`endif
    end
    if (clr) begin e_err = 0; e_cnt = 0; end
    else if (mis) begin e_err = 1; e_cnt = (e_cnt == CMAX) ? CMAX : e_cnt + 1; end
    #1 check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_busy", int'(init_busy), 1);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_data", int'(rd_data), 0);
    chk("rst_cnt", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    do_reset();
    chk("rst_err", int'(parity_err), 0);
    for (int i = 0; i < DEPTH; i++)
      tick($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255), 1'b1, $urandom_range(0, 7), 1'b0, 1'b0);
    chk("init_done", int'(init_busy), 0);
    tick(0, 0, 0, 1, 5, 0, 0);
    chk("rd5_data", int'(rd_data), 8'h00);
    tick(1, 2, 8'h07, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 2, 0, 0);
    chk("rd2_par", int'(rd_parity), 1 ^ PODD);
    tick(1, 3, 8'h55, 0, 0, 0, 0);
    tick(1, 3, 8'hAA, 1, 3, 0, 0);
    chk("rf_old", int'(rd_data), 8'h55);
    tick(0, 0, 0, 1, 3, 0, 0);
    chk("rf_new", int'(rd_data), 8'hAA);
    tick(1, 9, 8'h3C, 1, 9, 0, 0);
    chk("oob_valid", int'(rd_valid), 0);
    for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 1, i, 0, 0);
`ifdef MEM_PARITY_INJECT_EN
    tick(1, 1, 8'h01, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 1, 0, 0);
    chk("inj_err", int'(parity_err), 1);
    chk("inj_cnt", int'(err_count), 3);
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("clr_cnt", int'(err_count), 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 1, 0, 0);
    chk("sat_cnt", int'(err_count), CMAX);
    tick(0, 0, 0, 1, 1, 1, 0);
    chk("clr_wins", int'(err_count), 0);
`endif
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
           $urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 19) == 0,
`ifdef MEM_PARITY_INJECT_EN
           $urandom_range(0, 3) == 0);
`else
           1'b0);
`endif
    tick(1, 0, 8'hFF, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    chk("rst_rd0", int'(rd_data), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_parity_ram.md
# mem_parity_ram

Parametrised single-port-write / single-port-read RAM with a per-word parity bit. Parity is generated on every write and checked on every read, and an error flag and a saturating error counter are raised on mismatch. An init state machine clears the whole array after reset. It is the successor to the fixed 8×8 parity lookup table and serves as the protected storage block for lab datapaths.

## Interface
Parameters:
- `DATA_W`, 8: data word width.
- `DEPTH`, 8: number of words; must be ≥2.
- `ADDR_W`, 3: address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `CNT_W`, 8: error counter width.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: write strobe.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `rd_en` in 1: read strobe.
- `rd_addr` in ADDR_W: read address.
- `err_clr` in 1: synchronous clear of `err_count` and `parity_err`.
- `rd_data` out DATA_W: registered read data.
- `rd_parity` out 1: stored parity bit of the word read.
- `rd_valid` out 1: one-cycle pulse; `rd_data` and `rd_parity` are valid.
- `parity_err` out 1: sticky flag, set on any read mismatch.
- `err_count` out CNT_W: saturating count of read mismatches.
- `init_busy` out 1: high while the array is being cleared.

## Operation
- Storage is DEPTH × (DATA_W+1) bits: data plus one parity bit.
- Write parity is `^wr_data` when PARITY_ODD=0 and `~^wr_data` when PARITY_ODD=1.
- The state machine has two states, INIT and RUN.
  - Reset enters INIT with the internal pointer at 0.
  - In INIT, each cycle writes zero data with correct parity (0 for even, 1 for odd) at the pointer, then increments the pointer.
  - When the pointer reaches DEPTH−1 and that word is written, the FSM moves to RUN.
  - RUN is terminal until the next reset.
- In INIT, `wr_en` and `rd_en` are ignored; no `rd_valid` is produced.
- In RUN, an access with address ≥ DEPTH is ignored: a write does nothing, and a read produces no `rd_valid` and no error.
- Read check: the stored data's parity is recomputed and compared with the stored bit.
  - On mismatch in the same cycle as `rd_valid`, `parity_err` is set.
  - On mismatch, `err_count` increments unless it is already at all-ones (saturates).
- `err_clr` clears both `parity_err` and `err_count`. If `err_clr` and a mismatch occur in the same cycle, `err_clr` wins and the count ends at 0.
- Reset mid-operation: the FSM returns to INIT immediately and the array is re-cleared.

## Timing
- Reset values:
  - `rd_data` 0, `rd_parity` 0, `rd_valid` 0.
  - `parity_err` 0, `err_count` 0.
  - `init_busy` 1.
- INIT lasts exactly DEPTH cycles after `rst_n` deasserts. `init_busy` falls on the edge that completes the last clear write.
- Write: array updated at the rising edge where `wr_en`=1.
- Read latency is 1 cycle: `rd_en` sampled at edge N gives `rd_data`, `rd_parity` and `rd_valid`=1 after edge N.
  - `rd_valid` is 0 on cycles without a read.
  - `rd_data` holds its last value when no read occurs.
- Simultaneous write and read to the same address is read-first: the read returns the old word and old parity.
- Back-to-back reads are accepted every cycle.
- `parity_err` and `err_count` update on the same edge that asserts `rd_valid`.

## Configuration
- Macro: `MEM_PARITY_INJECT_EN`.
- Defined: adds input port `inj_err` (1 bit). When `inj_err`=1 during a RUN write, the stored parity bit is inverted. This is used to exercise the checker.
- Undefined: the `inj_err` port does not exist and parity is always stored correctly.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle, DEPTH=8:
  - `init_busy`=1 for 8 cycles, then 0.
  - Reading address 5 gives `rd_data`=0x00, `rd_parity`=0, `rd_valid` pulse, `parity_err`=0.
- Write 0x07 at address 2, read address 2 next cycle → `rd_data`=0x07, `rd_parity`=1 (even). With PARITY_ODD=1 → `rd_parity`=0.
- Write 0xAA at address 3 and read address 3 in the same cycle, after a prior 0x55 there → read returns 0x55; a following read returns 0xAA.
- `MEM_PARITY_INJECT_EN` defined: write 0x01 at address 1 with `inj_err`=1, then read it 3 times → `parity_err`=1 and `err_count`=3.
  - Pulse `err_clr` → both return to 0.
  - With CNT_W=2 and 5 bad reads → `err_count` holds at 3.
- Assert `rst_n` low mid-stream after writing 0xFF at address 0 → `init_busy` returns to 1; after 8 cycles, reading address 0 gives 0x00.
- Read or write at address 9 with DEPTH=8, ADDR_W=4 → no `rd_valid`, no error, array unchanged.
